// File: rtl/data_mover_sched_if.sv
// data_mover_sched_if
//   Bundles the request, mover-control, B-channel snoop and completion
//   signals of the data_mover scheduler.
//   Parameter: NUM_REQ - number of requesters (2..16).
//   Modports:
//     master - host/mover side: drives req_valid, req_addr, dst_bvalid,
//              dst_bresp; observes everything the scheduler produces.
//     slave  - scheduler side: the reverse.
interface data_mover_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [64*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mover_start;
  logic [63:0]           mover_dest_address;
  logic                  dst_bvalid;
  logic [1:0]            dst_bresp;
  logic                  done_valid;
  logic [IW-1:0]         done_id;
  logic                  done_error;
  logic                  busy;

  modport master (
    output req_valid, req_addr, dst_bvalid, dst_bresp,
    input  req_ready, mover_start, mover_dest_address,
           done_valid, done_id, done_error, busy
  );

  modport slave (
    input  req_valid, req_addr, dst_bvalid, dst_bresp,
    output req_ready, mover_start, mover_dest_address,
           done_valid, done_id, done_error, busy
  );
endinterface

// File: rtl/data_mover_sched.sv
// data_mover_sched
//   Round-robin scheduler sharing one data_mover among NUM_REQ requesters.
//   Grants one request at a time, pulses mover_start with the granted
//   destination address, counts DST_AXI B responses until the whole move
//   (BYTE_COUNT/BURST_SIZE bursts) is acknowledged, then reports a tagged
//   completion with error status.
//   Ports:
//     clk    - clock
//     resetn - synchronous active-low reset
//     bus    - data_mover_sched_if.slave (requests, mover start/address,
//              B-channel snoop, completion, busy)
//   Optional feature: define DATA_MOVER_SCHED_TIMEOUT_EN to enable a
//   WAIT_B watchdog of TIMEOUT_CYCLES cycles that forces an error completion.
//
//   state  | meaning
//   IDLE   | arbitrating; accepts one request per visit
//   START  | one-cycle mover_start pulse
//   WAIT_B | counting B responses of the move in flight
//   DONE   | one-cycle completion report
module data_mover_sched #(
  parameter int NUM_REQ        = 4,
  parameter int BYTE_COUNT     = 1048576,
  parameter int BURST_SIZE     = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic             clk,
  input logic             resetn,
  data_mover_sched_if.slave bus
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int BPM = BYTE_COUNT / BURST_SIZE;
  localparam int BW  = $clog2(BPM + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_B, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant, cur_id, grant_id;
  logic          grant_found;
  logic [63:0]   grant_addr;
  logic [BW-1:0] b_count;
  logic          err;
  logic          last_beat;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_found && bus.req_valid[IW'((int'(last_grant) + i) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = IW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) grant_addr = bus.req_addr[64*i +: 64];
    end
  end

  assign last_beat = bus.dst_bvalid && (b_count == BW'(BPM - 1));

`ifdef DATA_MOVER_SCHED_TIMEOUT_EN
  logic [31:0] wd_count;
  logic        wd_expired;

  assign wd_expired = (state == WAIT_B) && (wd_count == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!resetn)               wd_count <= '0;
    else if (state == START)   wd_count <= '0;
    else if (state == WAIT_B)  wd_count <= wd_count + 32'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A zero address would be ignored by the mover, so skip straight to an error completion.
      IDLE:   if (grant_found) state_nxt = (grant_addr == '0) ? DONE : START;
      START:  state_nxt = WAIT_B;
      WAIT_B: begin
        if (last_beat) state_nxt = DONE;
`ifdef DATA_MOVER_SCHED_TIMEOUT_EN
        else if (wd_expired) state_nxt = DONE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant             <= IW'(NUM_REQ - 1);
      cur_id                 <= '0;
      bus.mover_dest_address <= '0;
      b_count                <= '0;
      err                    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur_id                 <= grant_id;
            last_grant             <= grant_id;
            bus.mover_dest_address <= grant_addr;
            b_count                <= '0;
            err                    <= (grant_addr == '0);
          end
        end
        WAIT_B: begin
          if (bus.dst_bvalid) begin
            b_count <= b_count + BW'(1);
            if (bus.dst_bresp != 2'b00) err <= 1'b1;
          end
`ifdef DATA_MOVER_SCHED_TIMEOUT_EN
          if (wd_expired && !last_beat) err <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.mover_start = 1'b0;
    bus.done_valid  = 1'b0;
    bus.done_id     = '0;
    bus.done_error  = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      // Gated by resetn so no accept is advertised while reset is held.
      IDLE:  if (grant_found && resetn) bus.req_ready[grant_id] = 1'b1;
      START: bus.mover_start = 1'b1;
      DONE: begin
        bus.done_valid = 1'b1;
        bus.done_id    = cur_id;
        bus.done_error = err;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/data_mover_sched.md
# data_mover_sched

Round-robin scheduler that shares one `data_mover` instance among `NUM_REQ` requesters. Each requester presents a destination address. The scheduler arbitrates between requesters, issues a one-cycle `start` with the granted address, and snoops the mover's DST_AXI B-channel. It counts write responses until the whole move is acknowledged, then reports completion and error status tagged with the requester ID. It sits between the host-side request logic and the `data_mover` `start`/`dest_address` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `BYTE_COUNT`, 1048576: bytes per move; must equal the mover's value.
- `BURST_SIZE`, 4096: bytes per burst; must equal the mover's value. `BPM = BYTE_COUNT/BURST_SIZE`, an integer ≥1.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit; used only with `DATA_MOVER_SCHED_TIMEOUT_EN`.
- `IW`, derived: `$clog2(NUM_REQ)`.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: request pending, one bit per requester; held until accepted.
- `req_addr` in 64*NUM_REQ: destination addresses; requester i owns bits [64i+63:64i].
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `mover_start` out 1: one-cycle start pulse to `data_mover`.
- `mover_dest_address` out 64: destination address to `data_mover`.
- `dst_bvalid` in 1: snoop of DST_AXI_BVALID. BREADY is tied high in the mover.
- `dst_bresp` in 2: snoop of DST_AXI_BRESP.
- `done_valid` out 1: one-cycle completion pulse.
- `done_id` out IW: requester ID the completion belongs to.
- `done_error` out 1: completion had an error.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, START, WAIT_B and DONE. The reset state is IDLE.
- IDLE, arbitration:
  - If any `req_valid` bit is set, grant `g` = the first set bit searching upward from `last_grant+1`, wrapping at NUM_REQ.
  - `req_ready[g]` is combinational, asserted in this cycle only.
  - Latch `cur_id<=g`, `mover_dest_address<=req_addr[g]` and `last_grant<=g`.
  - Clear `b_count` and `err`.
  - If `req_addr[g]==0`, set `err<=1` and go to DONE. The mover ignores a zero address, so no start is issued.
  - Otherwise go to START.
- START: `mover_start=1` for this cycle only, then go to WAIT_B.
- WAIT_B:
  - Each `dst_bvalid` cycle increments `b_count`.
  - If `dst_bresp!=0` on such a cycle, set `err<=1`.
  - When the increment makes `b_count==BPM`, go to DONE. The error status includes the BRESP of that final beat.
- DONE: `done_valid=1`, `done_id=cur_id`, `done_error=err`, then go to IDLE.
- `dst_bvalid` outside WAIT_B is ignored.
- Widths:
  - `b_count` is `$clog2(BPM+1)` bits and never wraps.
  - `last_grant` is IW bits and resets to NUM_REQ-1, so requester 0 wins first.
- `mover_dest_address` holds its value from the grant until the next grant.
- Reset values:
  - `mover_start`=0, `mover_dest_address`=0, `req_ready`=0.
  - `done_valid`=0, `done_id`=0, `done_error`=0, `busy`=0.
- Reset mid-operation: the FSM returns to IDLE and the in-flight completion is lost. The mover shares `resetn` and is expected to reset with the scheduler.

## Timing
- Request accepted at cycle T, which requires IDLE with `req_valid` set. Then:
  - `mover_start` is asserted at T+1.
  - WAIT_B is entered at T+2.
- Last B beat at cycle F: `done_valid` at F+1, IDLE at F+2. The earliest next accept is F+2.
- Zero-address request accepted at T: `done_valid` with `done_error=1` at T+1.
- Only one move is ever in flight; no overlap with the mover's previous operation is possible.
- `req_valid` deasserted before acceptance is legal; the request is simply not granted.

## Configuration
- `DATA_MOVER_SCHED_TIMEOUT_EN` defined:
  - A 32-bit watchdog clears on entering WAIT_B and increments every WAIT_B cycle.
  - On reaching `TIMEOUT_CYCLES` with `b_count<BPM`, set `err<=1` and go to DONE.
  - Late B beats from the abandoned move are ignored while in DONE or IDLE. They would be miscounted if a new move had started, so software must reset the system after a timeout.
- Undefined: no watchdog; WAIT_B waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- Single request. Stimulus: BYTE_COUNT=16384, BURST_SIZE=4096, `req_valid[0]=1`, `req_addr[0]=0x1000_0000`. Required: `req_ready=4'b0001` at T, `mover_start` at T+1 with address 0x1000_0000. After 4 OKAY B beats, `done_valid=1`, `done_id=0`, `done_error=0` one cycle after the 4th beat.
- Round robin. Stimulus: all four `req_valid` held high, with B beats modelled for each move. Required: grant order 0,1,2,3,0; `busy` high throughout except in the IDLE accept cycles.
- Zero address. Stimulus: `req_valid[2]=1`, `req_addr[2]=0`. Required: `mover_start` never asserted; `done_valid=1`, `done_id=2`, `done_error=1` at T+1.
- BRESP error. Stimulus: third of four B beats carries BRESP=2'b10. Required: `done_error=1`, and `done_valid` only after the 4th beat.
- Reset mid WAIT_B. Stimulus: `resetn=0` after 2 of 4 beats. Required: all outputs at reset values the next cycle, and no `done_valid` is produced.
- Timeout. Stimulus: macro defined, TIMEOUT_CYCLES=100, only 1 B beat delivered. Required: `done_error=1`, `done_valid` 101 cycles after WAIT_B entry. With the macro undefined, the FSM remains in WAIT_B.
